// File: rtl/irq_request_latch.sv
// Request front end for a 4-input priority encoder: synchronizes and edge-detects
// request lines into sticky pending bits, and runs a valid/ack handshake with a settle gap.
module irq_request_latch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    output logic [3:0] pend_vec,
    output logic       irq_valid,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    output logic [3:0] overflow,
    input  logic       clr_ovf
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StAcked
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] prev_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] overflow_q, overflow_d;
    logic [3:0] evt;
    logic [3:0] clr_vec;
    logic [3:0] ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Encoder index 00 names bit 3, so the clear vector shifts down from the MSB.
    always_comb begin
        clr_vec = '0;
        if (state_q == StPend && ack) begin
            clr_vec = 4'b1000 >> ack_idx;
        end
    end

    always_comb begin
        ovf_set    = evt & pending_q & ~clr_vec;
        pending_d  = evt | (pending_q & ~clr_vec);
        overflow_d = ovf_set | (clr_ovf ? 4'b0000 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pend_vec = pending_q & mask;
    assign overflow = overflow_q;

    // A masked-off request in PEND still waits for ack; only IDLE looks at pend_vec.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|pend_vec) state_d = StPend;
            StPend:  if (ack) state_d = StAcked;
            StAcked: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign irq_valid = (state_q == StPend);

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: vector table for the basic flows plus
// hand-written sequences for mask, overflow, set/clear collision and async reset.
module tb_irq_request_latch;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic [3:0] pend_vec;
    logic       irq_valid;
    logic       ack;
    logic [1:0] ack_idx;
    logic [3:0] overflow;
    logic       clr_ovf;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] irq;
        logic [3:0] msk;
        logic       ak;
        logic [1:0] idx;
        logic       clr;
        logic [3:0] e_pend;
        logic       e_valid;
        logic [3:0] e_ovf;
    } vec_t;

    vec_t vecs[$];

    irq_request_latch #(
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .mask     (mask),
        .pend_vec (pend_vec),
        .irq_valid(irq_valid),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] ep, input logic ev,
                             input logic [3:0] eo);
        check({name, ".pend_vec"}, pend_vec, ep);
        check({name, ".irq_valid"}, {3'b000, irq_valid}, {3'b000, ev});
        check({name, ".overflow"}, overflow, eo);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic add(input logic [3:0] irq, input logic [3:0] msk, input logic ak,
                       input logic [1:0] idx, input logic [3:0] ep, input logic ev);
        vec_t v;
        v.irq = irq; v.msk = msk; v.ak = ak; v.idx = idx; v.clr = 1'b0;
        v.e_pend = ep; v.e_valid = ev; v.e_ovf = 4'h0;
        vecs.push_back(v);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        irq_in  = 4'h0;
        mask    = 4'hF;
        ack     = 1'b0;
        ack_idx = 2'b00;
        clr_ovf = 1'b0;

        // Single request on bit 2, serviced with index 01.
        add(4'h4, 4'hF, 0, 2'd0, 4'h0, 0);
        add(4'h4, 4'hF, 0, 2'd0, 4'h0, 0);
        add(4'h4, 4'hF, 0, 2'd0, 4'h4, 0);
        add(4'h4, 4'hF, 0, 2'd0, 4'h4, 1);
        add(4'h4, 4'hF, 1, 2'd1, 4'h0, 0);
        add(4'h4, 4'hF, 0, 2'd0, 4'h0, 0);
        add(4'h4, 4'hF, 0, 2'd0, 4'h0, 0);
        for (int k = 0; k < 3; k++) add(4'h0, 4'hF, 0, 2'd0, 4'h0, 0);
        // Two simultaneous requests, highest serviced first.
        add(4'h9, 4'hF, 0, 2'd0, 4'h0, 0);
        add(4'h9, 4'hF, 0, 2'd0, 4'h0, 0);
        add(4'h9, 4'hF, 0, 2'd0, 4'h9, 0);
        add(4'h9, 4'hF, 0, 2'd0, 4'h9, 1);
        add(4'h9, 4'hF, 1, 2'd0, 4'h1, 0);
        add(4'h9, 4'hF, 0, 2'd0, 4'h1, 0);
        add(4'h9, 4'hF, 0, 2'd0, 4'h1, 1);
        add(4'h9, 4'hF, 1, 2'd3, 4'h0, 0);
        add(4'h9, 4'hF, 0, 2'd0, 4'h0, 0);
        for (int k = 0; k < 3; k++) add(4'h0, 4'hF, 0, 2'd0, 4'h0, 0);
        // Masked line latches but stays invisible.
        for (int k = 0; k < 4; k++) add(4'h8, 4'h7, 0, 2'd0, 4'h0, 0);

        tick_n(2);
        check_all("reset", 4'h0, 1'b0, 4'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            irq_in  = vecs[i].irq;
            mask    = vecs[i].msk;
            ack     = vecs[i].ak;
            ack_idx = vecs[i].idx;
            clr_ovf = vecs[i].clr;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_valid, vecs[i].e_ovf);
        end
        ack = 1'b0;

        // Unmask: visible in the same cycle, valid one edge later.
        mask = 4'hF;
        #1;
        check_all("unmask_comb", 4'h8, 1'b0, 4'h0);
        tick();
        check_all("unmask_valid", 4'h8, 1'b1, 4'h0);
        ack = 1'b1; ack_idx = 2'd0;
        tick();
        ack = 1'b0;
        check_all("unmask_ack", 4'h0, 1'b0, 4'h0);
        tick();
        irq_in = 4'h0;
        tick_n(3);

        // Overflow on bit 1, then clear it while pending holds.
        irq_in = 4'h2;
        tick_n(3);
        check_all("ovf_first", 4'h2, 1'b0, 4'h0);
        irq_in = 4'h0;
        tick_n(3);
        irq_in = 4'h2;
        tick_n(3);
        check_all("ovf_set", 4'h2, 1'b1, 4'h2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_all("ovf_clr", 4'h2, 1'b1, 4'h0);
        ack = 1'b1; ack_idx = 2'd2;
        tick();
        ack = 1'b0;
        check_all("ovf_ack", 4'h0, 1'b0, 4'h0);
        tick();
        irq_in = 4'h0;
        tick_n(3);

        // New event on bit 2 lands on the same edge as its ack: set wins, no overflow.
        irq_in = 4'h4;
        tick_n(4);
        check_all("coll_pend", 4'h4, 1'b1, 4'h0);
        irq_in = 4'h0;
        tick_n(3);
        irq_in = 4'h4;
        tick_n(2);
        ack = 1'b1; ack_idx = 2'd1;
        tick();
        ack = 1'b0;
        check_all("coll_edge", 4'h4, 1'b0, 4'h0);
        tick();
        check_all("coll_gap", 4'h4, 1'b0, 4'h0);
        tick();
        check_all("coll_again", 4'h4, 1'b1, 4'h0);
        ack = 1'b1; ack_idx = 2'd1;
        tick();
        ack = 1'b0;
        tick();

        // Asynchronous reset while PEND with 1010 outstanding.
        irq_in = 4'hA;
        tick_n(4);
        check_all("pre_reset", 4'hA, 1'b1, 4'h0);
        irq_in = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 4'h0, 1'b0, 4'h0);
        tick_n(2);
        rst_n = 1'b1;
        tick_n(4);
        check_all("post_reset", 4'h0, 1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
